// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler: arbitrates mem wait, multi-cycle multiply,
// taken branch and load-use into one set of pipeline enables.
// Optional macro STALL_PERF_EN adds stall/flush performance counters.
module pipeline_stall_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_use_req,
    input  logic        branch_taken,
    input  logic        mul_start,
    input  logic        mem_busy,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXWrite,
    output logic        HazardMux,
    output logic        EXMEMWrite,
    output logic        EXMEMBubble,
    output logic        MEMWBWrite,
    output logic        mul_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int CW = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] CNT_LOAD = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;
    localparam logic MUL_EN = (MUL_LAT > 1);

    typedef enum logic {RUN, MUL} stateT;

    stateT          state;
    stateT          stateNext;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cntNext;

    // Priority arbitration of stall sources into enables and next state
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXWrite   = 1'b1;
        HazardMux   = 1'b0;
        EXMEMWrite  = 1'b1;
        EXMEMBubble = 1'b0;
        MEMWBWrite  = 1'b1;
        stateNext   = state;
        cntNext     = cnt;
        if (reset) begin
            stateNext = RUN;
            cntNext   = '0;
        end else if (mem_busy) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBWrite = 1'b0;
        end else if (state == MUL && cnt != '0) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
            cntNext     = cnt - 1'b1;
        end else if (state == RUN && mul_start && MUL_EN) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMBubble = 1'b1;
            stateNext   = MUL;
            cntNext     = CNT_LOAD;
        end else begin
            // Release cycle of MUL behaves like RUN without re-arming
            stateNext = RUN;
            if (branch_taken) begin
                IFIDFlush = 1'b1;
                HazardMux = 1'b1;
            end else if (load_use_req) begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                HazardMux = 1'b1;
            end
        end
    end

    // State and multiply countdown register
    always_ff @(posedge clk) begin
        state <= stateNext;
        cnt   <= cntNext;
    end

    assign mul_busy = (state == MUL);

`ifdef STALL_PERF_EN
    // Performance counters for stalled and flushed cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PCWrite)
                stall_cycles <= stall_cycles + 32'd1;
            if (IFIDFlush)
                flush_count <= flush_count + 32'd1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed scoreboard bench for pipeline_stall_ctrl (MUL_LAT=4 and MUL_LAT=1).
// Control vector order: PC IFIDW FLUSH IDEXW HMUX EXMEMW EXMEMB MEMWBW.
module tb_pipeline_stall_ctrl;

    localparam logic [7:0] IDLE   = 8'b1101_0101;
    localparam logic [7:0] FREEZE = 8'b0000_0000;
    localparam logic [7:0] MULST  = 8'b0000_0111;
    localparam logic [7:0] BRANCH = 8'b1111_1101;
    localparam logic [7:0] LDUSE  = 8'b0001_1101;

    typedef struct {
        string      tag;
        logic [8:0] v;
    } expT;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic loadUse = 1'b0;
    logic branch = 1'b0;
    logic mulStart = 1'b0;
    logic memBusy = 1'b0;
    logic mulStart1 = 1'b0;
    logic zero = 1'b0;

    logic pcW, ifidW, ifidF, idexW, hMux, exmemW, exmemB, memwbW, busy;
    logic [31:0] stallCnt, flushCnt;
    logic pcW1, ifidW1, ifidF1, idexW1, hMux1, exmemW1, exmemB1, memwbW1, busy1;
    logic [31:0] stallCnt1, flushCnt1;

    expT  sb[$];
    int   checks = 0;
    int   errors = 0;
    int   expStall = 0;
    int   expFlush = 0;
    bit   started = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .load_use_req(loadUse), .branch_taken(branch),
        .mul_start(mulStart), .mem_busy(memBusy),
        .PCWrite(pcW), .IFIDWrite(ifidW), .IFIDFlush(ifidF),
        .IDEXWrite(idexW), .HazardMux(hMux), .EXMEMWrite(exmemW),
        .EXMEMBubble(exmemB), .MEMWBWrite(memwbW), .mul_busy(busy),
        .stall_cycles(stallCnt), .flush_count(flushCnt)
    );

    pipeline_stall_ctrl #(.MUL_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .load_use_req(zero), .branch_taken(zero),
        .mul_start(mulStart1), .mem_busy(zero),
        .PCWrite(pcW1), .IFIDWrite(ifidW1), .IFIDFlush(ifidF1),
        .IDEXWrite(idexW1), .HazardMux(hMux1), .EXMEMWrite(exmemW1),
        .EXMEMBubble(exmemB1), .MEMWBWrite(memwbW1), .mul_busy(busy1),
        .stall_cycles(stallCnt1), .flush_count(flushCnt1)
    );

    task automatic checkCounters();
        logic [31:0] es, ef;
`ifdef STALL_PERF_EN
        es = 32'(expStall);
        ef = 32'(expFlush);
`else
        es = '0;
        ef = '0;
`endif
        checks++;
        assert (stallCnt === es) else begin
            errors++;
            $error("FAIL stall_cycles: observed %0d expected %0d", stallCnt, es);
        end
        checks++;
        assert (flushCnt === ef) else begin
            errors++;
            $error("FAIL flush_count: observed %0d expected %0d", flushCnt, ef);
        end
    endtask

    task automatic step(input logic rst, input logic lu, input logic br,
                        input logic ms, input logic mb,
                        input logic [7:0] ctl, input logic bsy,
                        input string tag);
        expT e;
        expT got;
        logic [8:0] obs;
        @(negedge clk);
        if (started)
            checkCounters();
        reset    = rst;
        loadUse  = lu;
        branch   = br;
        mulStart = ms;
        memBusy  = mb;
        e.tag = tag;
        e.v   = {ctl, bsy};
        sb.push_back(e);
        if (rst) begin
            expStall = 0;
            expFlush = 0;
            started  = 1;
        end else begin
            if (!ctl[7]) expStall++;
            if (ctl[5])  expFlush++;
        end
        #2;
        obs = {pcW, ifidW, ifidF, idexW, hMux, exmemW, exmemB, memwbW, busy};
        got = sb.pop_front();
        checks++;
        assert (obs === got.v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", got.tag, obs, got.v);
        end
    endtask

    initial begin
        logic [8:0] obs1;
        step(1, 0, 0, 0, 0, IDLE, 0, "reset0");
        step(1, 0, 0, 0, 0, IDLE, 0, "reset1");
        step(0, 0, 0, 0, 0, IDLE, 0, "idle");

        step(0, 1, 0, 0, 0, LDUSE, 0, "lduse");
        step(0, 0, 0, 0, 0, IDLE, 0, "lduse_after");

        step(0, 1, 1, 0, 0, BRANCH, 0, "br_lduse");
        step(0, 0, 0, 0, 0, IDLE, 0, "br_after");

        step(0, 0, 0, 1, 0, MULST, 0, "mul_c1");
        step(0, 0, 0, 1, 0, MULST, 1, "mul_c2");
        step(0, 0, 0, 1, 0, MULST, 1, "mul_c3");
        step(0, 0, 0, 1, 0, IDLE,  1, "mul_release");
        step(0, 0, 0, 0, 0, IDLE,  0, "mul_done");

        step(0, 0, 0, 1, 0, MULST,  0, "mulmb_c1");
        step(0, 0, 0, 1, 1, FREEZE, 1, "mulmb_fz1");
        step(0, 0, 0, 1, 1, FREEZE, 1, "mulmb_fz2");
        step(0, 0, 0, 1, 0, MULST,  1, "mulmb_c4");
        step(0, 0, 0, 1, 0, MULST,  1, "mulmb_c5");
        step(0, 0, 0, 1, 0, IDLE,   1, "mulmb_release");
        step(0, 0, 0, 0, 0, IDLE,   0, "mulmb_done");

        step(0, 0, 0, 1, 0, MULST, 0, "mulrst_c1");
        step(1, 0, 0, 1, 0, IDLE,  1, "mulrst_reset");
        step(0, 0, 0, 0, 0, IDLE,  0, "mulrst_after");
        step(0, 0, 0, 0, 0, IDLE,  0, "mulrst_quiet");

        step(0, 0, 0, 1, 1, FREEZE, 0, "mbstart_fz");
        step(0, 0, 0, 1, 0, MULST,  0, "mbstart_c1");
        step(0, 0, 0, 1, 0, MULST,  1, "mbstart_c2");
        step(0, 0, 0, 1, 0, MULST,  1, "mbstart_c3");
        step(0, 0, 0, 1, 0, IDLE,   1, "mbstart_release");
        step(0, 0, 0, 0, 0, IDLE,   0, "mbstart_done");

        step(0, 0, 0, 1, 0, MULST, 0, "mullu_c1");
        step(0, 0, 0, 1, 0, MULST, 1, "mullu_c2");
        step(0, 0, 0, 1, 0, MULST, 1, "mullu_c3");
        step(0, 1, 0, 1, 0, LDUSE, 1, "mullu_release");
        step(0, 0, 0, 0, 0, IDLE,  0, "mullu_done");

        step(0, 0, 1, 0, 0, BRANCH, 0, "branch_only");
        step(0, 0, 0, 0, 0, IDLE,   0, "final_idle");

        @(negedge clk);
        checkCounters();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mulStart1 = 1'b1;
            #2;
            obs1 = {pcW1, ifidW1, ifidF1, idexW1, hMux1,
                    exmemW1, exmemB1, memwbW1, busy1};
            checks++;
            assert (obs1 === {IDLE, 1'b0}) else begin
                errors++;
                $error("FAIL lat1_mul: observed %b expected %b", obs1, {IDLE, 1'b0});
            end
        end
        mulStart1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
